alt_vipcts131_common_stream_output: RTL and testbench

Transmit-side counterpart of the common stream input stage. Accepts beats on the internal valid/ready interface (ready latency 0) and drives an Avalon-ST output with ready latency 1 and registered outputs. Stops output only at packet boundaries, so downstream blocks can be enabled or disabled cleanly. Sits at the output edge of every VIP core, after the core's processing datapath.

---
 rtl/alt_vipcts131_stream_pkg.sv | 7 +
 rtl/alt_vipcts131_common_stream_fifo.sv | 55 +++++
 rtl/alt_vipcts131_common_stream_output.sv | 97 +++++++++
 tb/tb_alt_vipcts131_common_stream_output.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/alt_vipcts131_stream_pkg.sv
// Shared definitions for the VIP common stream blocks: packet state encoding,
// output ready latency and statistics counter width.
package alt_vipcts131_stream_pkg;
  typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_e;
  localparam int READY_LATENCY = 1;
  localparam int STATS_W       = 16;
endpackage

// File: rtl/alt_vipcts131_common_stream_fifo.sv
// Circular beat buffer, DEPTH x WIDTH, with occupancy-derived full/empty.
// Head entry is presented combinationally on rdata_o.
module alt_vipcts131_common_stream_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/alt_vipcts131_common_stream_output.sv
// VIP stream output stage: internal valid/ready to registered Avalon-ST (ready latency 1),
// gating new packets on enable. VIP_STREAM_OUTPUT_STATS_EN adds packet/stall counters.
module alt_vipcts131_common_stream_output
  import alt_vipcts131_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  int_valid,
  output logic                  int_ready,
  input  logic [DATA_WIDTH-1:0] int_data,
  input  logic                  int_sop,
  input  logic                  int_eop,
  input  logic                  dout_ready,
  output logic                  dout_valid,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_sop,
  output logic                  dout_eop,
  input  logic                  enable,
  output logic                  synced
`ifdef VIP_STREAM_OUTPUT_STATS_EN
  ,
  output logic [STATS_W-1:0]    pkt_count,
  output logic [STATS_W-1:0]    overflow_stall
`endif
);
  localparam int EW = DATA_WIDTH + 2;

  logic [EW-1:0]         head;
  logic                  full, empty, push, pop, head_eop;
  state_e                state_q, state_d;
  logic                  dv_q, sop_q, eop_q, synced_q;
  logic [DATA_WIDTH-1:0] data_q;

  assign int_ready = ~full;
  assign push      = int_valid & ~full;
  // enable only gates the start of a packet; an open packet always drains.
  assign pop       = dout_ready & ~empty & ((state_q == IN_PKT) | enable);
  assign head_eop  = head[DATA_WIDTH];

  alt_vipcts131_common_stream_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({int_sop, int_eop, int_data}),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d = state_q;
    if (pop) state_d = head_eop ? IDLE : IN_PKT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dv_q     <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      data_q   <= '0;
      synced_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      dv_q     <= pop;
      synced_q <= (state_d == IDLE) & ~enable;
      if (pop) {sop_q, eop_q, data_q} <= head;
    end
  end

  assign dout_valid = dv_q;
  assign dout_data  = data_q;
  assign dout_sop   = sop_q;
  assign dout_eop   = eop_q;
  assign synced     = synced_q;

`ifdef VIP_STREAM_OUTPUT_STATS_EN
  logic [STATS_W-1:0] pkt_q, stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_q   <= '0;
      stall_q <= '0;
    end else begin
      if (pop & head_eop)                     pkt_q   <= pkt_q + STATS_W'(1);
      if (int_valid & full & (stall_q != '1)) stall_q <= stall_q + STATS_W'(1);
    end
  end

  assign pkt_count      = pkt_q;
  assign overflow_stall = stall_q;
`endif
endmodule

// File: tb/tb_alt_vipcts131_common_stream_output.sv
// Directed bench for the VIP stream output stage; stats checks need VIP_STREAM_OUTPUT_STATS_EN.
module tb_alt_vipcts131_common_stream_output;
  localparam int DW    = 10;
  localparam int DEPTH = 4;
  typedef logic [DW+1:0] beat_t; // {sop, eop, data}

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          int_valid = 1'b0, int_sop = 1'b0, int_eop = 1'b0;
  logic [DW-1:0] int_data = '0;
  logic          dout_ready = 1'b0, enable = 1'b0;
  logic          int_ready, dout_valid, dout_sop, dout_eop, synced;
  logic [DW-1:0] dout_data;
`ifdef VIP_STREAM_OUTPUT_STATS_EN
  logic [15:0]   pkt_count, overflow_stall;
`endif

  int    n_tests = 0, n_fail = 0;
  beat_t tx_q[$], rx_q[$];
  logic  hs, stall;

  alt_vipcts131_common_stream_output #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .int_valid(int_valid), .int_ready(int_ready),
    .int_data(int_data), .int_sop(int_sop), .int_eop(int_eop),
    .dout_ready(dout_ready), .dout_valid(dout_valid), .dout_data(dout_data),
    .dout_sop(dout_sop), .dout_eop(dout_eop), .enable(enable), .synced(synced)
`ifdef VIP_STREAM_OUTPUT_STATS_EN
    , .pkt_count(pkt_count), .overflow_stall(overflow_stall)
`endif
  );

  always #5 clk = ~clk;

  function automatic beat_t mk(input bit s, input bit e, input int d);
    return {s, e, d[DW-1:0]};
  endfunction

  // One clock: present the head of tx_q, note handshake, collect any output beat.
  task automatic tick();
    int_valid = (tx_q.size() != 0);
    {int_sop, int_eop, int_data} = int_valid ? tx_q[0] : '0;
    #1;
    hs    = int_valid & int_ready;
    stall = int_valid & ~int_ready;
    @(posedge clk); #1;
    if (hs) void'(tx_q.pop_front());
    if (dout_valid) rx_q.push_back({dout_sop, dout_eop, dout_data});
  endtask

  task automatic do_reset();
    rst_n = 1'b0; int_valid = 1'b0; int_sop = 1'b0; int_eop = 1'b0; int_data = '0;
    dout_ready = 1'b0; enable = 1'b0;
    tx_q.delete(); rx_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; dout_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", dout_valid); end
    n_tests++; if ({dout_sop, dout_eop} !== 2'b00) begin n_fail++; $display("FAIL reset_sop_eop: got %b want 00", {dout_sop, dout_eop}); end
    n_tests++; if (dout_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 000", dout_data); end
    n_tests++; if (synced !== 1'b1) begin n_fail++; $display("FAIL reset_synced: got %b want 1", synced); end
    n_tests++; if (int_ready !== 1'b1) begin n_fail++; $display("FAIL reset_int_ready: got %b want 1", int_ready); end
  endtask

  task automatic test_streaming();
    int first = -1, last = -1, nvalid = 0, ir_low = 0;
    do_reset(); enable = 1'b1; dout_ready = 1'b1;
    for (int i = 1; i <= 8; i++) tx_q.push_back(mk(i == 1, i == 8, i));
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (dout_valid) begin if (first < 0) first = t; last = t; nvalid++; end
      if (!int_ready) ir_low++;
    end
    n_tests++; if (first != 2) begin n_fail++; $display("FAIL stream_latency: got first valid at %0d want 2", first); end
    n_tests++; if (nvalid != 8 || last != 9) begin n_fail++; $display("FAIL stream_contiguous: got %0d beats ending %0d want 8 ending 9", nvalid, last); end
    n_tests++; if (ir_low != 0) begin n_fail++; $display("FAIL stream_int_ready: got %0d low cycles want 0", ir_low); end
    for (int i = 0; i < 8; i++) begin
      n_tests++; if (rx_q[i] !== mk(i == 0, i == 7, i + 1)) begin n_fail++; $display("FAIL stream_beat%0d: got %h want %h", i, rx_q[i], mk(i == 0, i == 7, i + 1)); end
    end
  endtask

  task automatic test_backpressure();
    int pushes = 0, dvhi = 0, irlow = 0;
    do_reset(); enable = 1'b1; dout_ready = 1'b1;
    for (int i = 0; i < 12; i++) tx_q.push_back(mk(i == 0, i == 11, 'h10 + i));
    repeat (3) tick();
    dout_ready = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (hs) pushes++;
      if (dout_valid) dvhi++;
      if (!int_ready) irlow++;
    end
    n_tests++; if (pushes != 3) begin n_fail++; $display("FAIL bp_pushes: got %0d want 3", pushes); end
    n_tests++; if (dvhi != 0) begin n_fail++; $display("FAIL bp_valid_low: got %0d valid cycles want 0", dvhi); end
    n_tests++; if (irlow != 8) begin n_fail++; $display("FAIL bp_int_ready_low: got %0d want 8", irlow); end
    dout_ready = 1'b1;
    tick();
    n_tests++; if ({hs, dout_valid, int_ready} !== 3'b011) begin n_fail++; $display("FAIL bp_release: got hs/valid/ready %b want 011", {hs, dout_valid, int_ready}); end
    for (int t = 0; t < 30 && (tx_q.size() != 0 || rx_q.size() < 12); t++) tick();
    n_tests++; if (rx_q.size() != 12) begin n_fail++; $display("FAIL bp_count: got %0d beats want 12", rx_q.size()); end
    for (int i = 0; i < 12; i++) begin
      n_tests++; if (rx_q[i] !== mk(i == 0, i == 11, 'h10 + i)) begin n_fail++; $display("FAIL bp_beat%0d: got %h want %h", i, rx_q[i], mk(i == 0, i == 11, 'h10 + i)); end
    end
  endtask

  task automatic test_enable_gating();
    int t;
    do_reset(); enable = 1'b1; dout_ready = 1'b1;
    for (int i = 0; i < 6; i++) tx_q.push_back(mk(i == 0, i == 5, 'h20 + i));
    tx_q.push_back(mk(1, 0, 'h30));
    tx_q.push_back(mk(0, 1, 'h31));
    for (t = 0; t < 20 && rx_q.size() < 3; t++) tick();
    n_tests++; if (rx_q.size() != 3) begin n_fail++; $display("FAIL en_reach_beat3: got %0d beats want 3", rx_q.size()); end
    enable = 1'b0;
    tick();
    n_tests++; if (synced !== 1'b0) begin n_fail++; $display("FAIL en_synced_midpkt: got %b want 0", synced); end
    repeat (15) tick();
    n_tests++; if (rx_q.size() != 6) begin n_fail++; $display("FAIL en_drain: got %0d beats want 6", rx_q.size()); end
    n_tests++; if (rx_q[5] !== mk(0, 1, 'h25)) begin n_fail++; $display("FAIL en_last_beat: got %h want %h", rx_q[5], mk(0, 1, 'h25)); end
    n_tests++; if ({dout_valid, synced} !== 2'b01) begin n_fail++; $display("FAIL en_stopped: got valid/synced %b want 01", {dout_valid, synced}); end
    enable = 1'b1;
    tick();
    n_tests++; if ({dout_valid, dout_sop, dout_data} !== {2'b11, 10'h030}) begin n_fail++; $display("FAIL en_resume: got %b%b %h want 11 030", dout_valid, dout_sop, dout_data); end
    n_tests++; if (synced !== 1'b0) begin n_fail++; $display("FAIL en_synced_resume: got %b want 0", synced); end
    repeat (3) tick();
    n_tests++; if (rx_q.size() != 8 || rx_q[7] !== mk(0, 1, 'h31)) begin n_fail++; $display("FAIL en_pkt_b: got %0d beats last %h want 8 last %h", rx_q.size(), rx_q[7], mk(0, 1, 'h31)); end
  endtask

  task automatic test_single_beat();
    int bad_en = 0, bad_sync = 0;
    do_reset(); dout_ready = 1'b1; enable = 1'b0;
    for (int i = 0; i < 5; i++) tx_q.push_back(mk(1, 1, 'h40 + i));
    for (int t = 0; t < 30; t++) begin
      enable = ~enable;
      tick();
      if (dout_valid && !enable) bad_en++;
      if (synced !== ~enable) bad_sync++;
    end
    n_tests++; if (bad_en != 0) begin n_fail++; $display("FAIL sb_enable_gate: got %0d beats with enable low want 0", bad_en); end
    n_tests++; if (bad_sync != 0) begin n_fail++; $display("FAIL sb_idle_synced: got %0d mismatching cycles want 0", bad_sync); end
    n_tests++; if (rx_q.size() != 5) begin n_fail++; $display("FAIL sb_count: got %0d want 5", rx_q.size()); end
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (rx_q[i] !== mk(1, 1, 'h40 + i)) begin n_fail++; $display("FAIL sb_beat%0d: got %h want %h", i, rx_q[i], mk(1, 1, 'h40 + i)); end
    end
  endtask

  task automatic test_async_reset();
    do_reset(); enable = 1'b1; dout_ready = 1'b0;
    for (int i = 0; i < 6; i++) tx_q.push_back(mk(i == 0, i == 5, 'h50 + i));
    repeat (3) tick();
    dout_ready = 1'b1;
    tick();
    n_tests++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL ar_pre_valid: got %b want 1", dout_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if ({dout_valid, dout_sop, dout_eop} !== 3'b000) begin n_fail++; $display("FAIL ar_outputs: got %b want 000", {dout_valid, dout_sop, dout_eop}); end
    n_tests++; if (dout_data !== '0) begin n_fail++; $display("FAIL ar_data: got %h want 000", dout_data); end
    n_tests++; if ({synced, int_ready} !== 2'b11) begin n_fail++; $display("FAIL ar_synced_ready: got %b want 11", {synced, int_ready}); end
    tx_q.delete(); rx_q.delete(); int_valid = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (3) tick();
    n_tests++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL ar_empty: got %0d stale beats want 0", rx_q.size()); end
    tx_q.push_back(mk(1, 0, 'h60));
    tx_q.push_back(mk(0, 1, 'h61));
    repeat (5) tick();
    n_tests++; if (rx_q.size() != 2) begin n_fail++; $display("FAIL ar_next_count: got %0d want 2", rx_q.size()); end
    n_tests++; if (rx_q[0] !== mk(1, 0, 'h60) || rx_q[1] !== mk(0, 1, 'h61)) begin n_fail++; $display("FAIL ar_next_pkt: got %h %h want %h %h", rx_q[0], rx_q[1], mk(1, 0, 'h60), mk(0, 1, 'h61)); end
  endtask

`ifdef VIP_STREAM_OUTPUT_STATS_EN
  task automatic test_stats();
    int st = 0;
    do_reset(); enable = 1'b1; dout_ready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      tx_q.push_back(mk(1, 0, 'h70 + p));
      tx_q.push_back(mk(0, 1, 'h78 + p));
    end
    repeat (10) tick();
    n_tests++; if (pkt_count !== 16'd3) begin n_fail++; $display("FAIL st_pkt_count: got %0d want 3", pkt_count); end
    n_tests++; if (overflow_stall !== 16'd0) begin n_fail++; $display("FAIL st_no_stall: got %0d want 0", overflow_stall); end
    dout_ready = 1'b0;
    for (int i = 0; i < 20; i++) tx_q.push_back(mk(0, 0, i));
    for (int t = 0; t < 30 && st < 5; t++) begin tick(); if (stall) st++; end
    int_valid = 1'b0; tx_q.delete();
    @(posedge clk); #1;
    n_tests++; if (overflow_stall !== 16'd5) begin n_fail++; $display("FAIL st_stall: got %0d want 5", overflow_stall); end
    n_tests++; if (pkt_count !== 16'd3) begin n_fail++; $display("FAIL st_pkt_hold: got %0d want 3", pkt_count); end
    do_reset(); enable = 1'b1; dout_ready = 1'b1;
    int_valid = 1'b1; int_sop = 1'b1; int_eop = 1'b1; int_data = '0;
    // Streaming single-beat packets: first edge only pushes, each later edge pops one eop.
    repeat (65536) @(posedge clk);
    #1;
    n_tests++; if (pkt_count !== 16'hFFFF) begin n_fail++; $display("FAIL st_pre_wrap: got %h want ffff", pkt_count); end
    @(posedge clk); #1;
    n_tests++; if (pkt_count !== 16'h0000) begin n_fail++; $display("FAIL st_wrap: got %h want 0000", pkt_count); end
    n_tests++; if (overflow_stall !== 16'd0) begin n_fail++; $display("FAIL st_wrap_stall: got %0d want 0", overflow_stall); end
    int_valid = 1'b0;
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_enable_gating();
    test_single_beat();
    test_async_reset();
`ifdef VIP_STREAM_OUTPUT_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
